// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory-port arbiter.
// Holds FSM state encodings, grant IDs, access-size codes and remap defaults.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INST = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } grant_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [15:0] REMAP_FROM_DEF = 16'hbfaf;
  localparam logic [15:0] REMAP_TO_DEF   = 16'h1faf;

  // Command captured at grant time and replayed on the memory port.
  typedef struct packed {
    logic        write;
    logic [1:0]  size;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] st_data;
  } mem_cmd_t;

  // Only the two aligned halfword patterns count as halfword accesses.
  function automatic logic [1:0] wen_to_size(input logic [3:0] wen);
    logic [1:0] size;
    case (wen)
      4'b1111:          size = SIZE_WORD;
      4'b0011, 4'b1100: size = SIZE_HALF;
      default:          size = SIZE_BYTE;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/mem_req_decode.sv
// Combinational decode of a data request: byte-enable to access size and
// optional remapping of one 64 KiB address window.
module mem_req_decode
  import mem_arb_pkg::*;
#(
  parameter bit          REMAP_EN   = 1'b1,
  parameter logic [15:0] REMAP_FROM = REMAP_FROM_DEF,
  parameter logic [15:0] REMAP_TO   = REMAP_TO_DEF
) (
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_wen,
  output logic [1:0]  size,
  output logic [31:0] addr
);

  logic in_window;

  assign in_window = REMAP_EN && (d_addr[31:16] == REMAP_FROM);
  assign size      = wen_to_size(d_wen);
  assign addr      = in_window ? {REMAP_TO, d_addr[15:0]} : d_addr;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one shared memory port between an instruction fetch port and a
// data port, alternating grants under contention and honouring data flush.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter bit          REMAP_EN   = 1'b1,
  parameter logic [15:0] REMAP_FROM = REMAP_FROM_DEF,
  parameter logic [15:0] REMAP_TO   = REMAP_TO_DEF
) (
  input  logic        clk,
  input  logic        rst,
  // instruction port
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  // data port
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_wen,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  input  logic        flush,
  // memory port
  output logic        mem_access,
  output logic        mem_write,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_a,
  output logic [31:0] mem_st_data,
  input  logic        mem_ready,
  input  logic [31:0] mem_data,
  output logic        busy
);

  arb_state_e  state_q, state_d;
  grant_e      last_q, last_d;
  mem_cmd_t    cmd_q, cmd_d;
  logic        i_ready_q, i_ready_d;
  logic        d_ready_q, d_ready_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic [1:0]  dec_size;
  logic [31:0] dec_addr;
  logic        d_req_eff;
  logic        grant_data;

  mem_req_decode #(
    .REMAP_EN   (REMAP_EN),
    .REMAP_FROM (REMAP_FROM),
    .REMAP_TO   (REMAP_TO)
  ) u_decode (
    .d_addr (d_addr),
    .d_wen  (d_wen),
    .size   (dec_size),
    .addr   (dec_addr)
  );

  // A flushed data request never reaches arbitration.
  assign d_req_eff  = d_req & ~flush;
  assign grant_data = d_req_eff && (!i_req || (last_q == GNT_INST));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    last_d    = last_q;
    cmd_d     = cmd_q;
    i_ready_d = 1'b0;
    d_ready_d = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_data) begin
          cmd_d.write   = d_write;
          cmd_d.size    = dec_size;
          cmd_d.sel     = d_wen;
          cmd_d.addr    = dec_addr;
          cmd_d.st_data = d_wdata;
          state_d       = ST_DATA;
        end else if (i_req) begin
          cmd_d.write   = 1'b0;
          cmd_d.size    = SIZE_WORD;
          cmd_d.sel     = 4'b1111;
          cmd_d.addr    = i_addr;
          cmd_d.st_data = '0;
          state_d       = ST_INST;
        end
      end
      ST_INST: begin
        if (mem_ready) begin
          i_rdata_d = mem_data;
          i_ready_d = 1'b1;
          last_d    = GNT_INST;
          state_d   = ST_RESP;
        end
      end
      ST_DATA: begin
        // An abort must not count as a grant for fairness purposes.
        if (flush) begin
          state_d = ST_IDLE;
        end else if (mem_ready) begin
          d_rdata_d = mem_data;
          d_ready_d = 1'b1;
          last_d    = GNT_DATA;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the read-data holding registers are cleared on reset too, so a
      // port never observes stale data from before reset.
      state_q   <= ST_IDLE;
      last_q    <= GNT_INST;
      cmd_q     <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the
      // same pre-edge values.
      state_q   <= state_d;
      last_q    <= last_d;
      cmd_q     <= cmd_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // The memory port shows the captured command only while an access is live.
  assign mem_access  = (state_q == ST_INST) || (state_q == ST_DATA);
  assign mem_write   = mem_access & cmd_q.write;
  assign mem_size    = mem_access ? cmd_q.size    : SIZE_BYTE;
  assign mem_sel     = mem_access ? cmd_q.sel     : 4'b0000;
  assign mem_a       = mem_access ? cmd_q.addr    : 32'h0;
  assign mem_st_data = mem_access ? cmd_q.st_data : 32'h0;

  assign busy    = (state_q != ST_IDLE);
  assign i_ready = i_ready_q;
  assign d_ready = d_ready_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter REMAP_EN, default 1, which enables data-address window remapping.
REQ-002 SHALL have parameter REMAP_FROM, default 16'hbfaf, which is the data address [31:16] value to be remapped.
REQ-003 SHALL have parameter REMAP_TO, default 16'h1faf, which is the replacement value for data address [31:16].
REQ-004 SHALL have one clock and an asynchronous, active-high reset, named as follows: clk, input, 1, clock; rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have the following instruction-port signals: i_req in 1, fetch request; i_addr in 32, fetch address; i_ready out 1, fetch done pulse; i_rdata out 32, fetched word.
REQ-006 SHALL have the following data-port signals: d_req in 1; d_write in 1; d_addr in 32; d_wen in 4 (byte select); d_wdata in 32; d_ready out 1; d_rdata out 32.
REQ-007 SHALL have flush, input, 1, which cancels the pending data access (exception in M stage).
REQ-008 SHALL have the following memory-port signals: mem_access out 1; mem_write out 1; mem_size out 2; mem_sel out 4; mem_a out 32; mem_st_data out 32; mem_ready in 1; mem_data in 32.
REQ-009 SHALL have busy, output, 1, asserted whenever state is not IDLE.

Function
REQ-010 SHALL implement states IDLE, INST, DATA and RESP.
REQ-011 In IDLE, the arbiter SHALL sample requests, grant one, register its command, and move to INST or DATA the next cycle.
REQ-012 With a single request, the arbiter SHALL grant that requester; with both requesting, it SHALL grant the one not granted last (last_grant register).
REQ-013 In IDLE, d_req SHALL be ignored in any cycle where flush=1.
REQ-014 In INST and DATA, the arbiter SHALL drive mem_access=1 and registered mem_a/mem_write/mem_size/mem_sel/mem_st_data until mem_ready=1.
REQ-015 In IDLE and RESP, all mem_* outputs SHALL be 0.
REQ-016 An INST grant SHALL drive mem_write=0, mem_sel=4'b1111, mem_size=2'b10, mem_a=i_addr.
REQ-017 A DATA grant SHALL drive mem_write=d_write, mem_sel=d_wen, mem_st_data=d_wdata.
REQ-018 For a DATA grant, mem_size SHALL be 2'b10 when d_wen=1111, 2'b01 when d_wen is 0011 or 1100, and 2'b00 otherwise.
REQ-019 For a DATA grant with REMAP_EN=1 and d_addr[31:16]==REMAP_FROM, mem_a SHALL be {REMAP_TO, d_addr[15:0]}; otherwise mem_a SHALL be d_addr.
REQ-020 When mem_ready=1 in INST or DATA, the arbiter SHALL capture mem_data into the granted port's rdata register and move to RESP.
REQ-021 In RESP, the arbiter SHALL pulse i_ready or d_ready (whichever was granted) for exactly one cycle and return to IDLE.
REQ-022 No request SHALL be sampled in RESP, so that a requester still holding req does not get a duplicate grant.
REQ-023 Minimum latency SHALL be: req sampled cycle N; mem_access cycles N+1..M; mem_ready at M; ready at M+1; next grant sampled at M+2.
REQ-024 i_rdata and d_rdata SHALL hold their last captured value until the next capture for that port.
REQ-025 flush=1 in DATA with mem_ready=0 SHALL abort the access: next state IDLE, no d_ready, d_rdata unchanged.
REQ-026 flush=1 in DATA in the same cycle as mem_ready=1 SHALL also abort, with no d_ready.
REQ-027 flush SHALL have no effect in INST or RESP.
REQ-028 Deassertion of i_req or d_req after a grant SHALL be ignored; the transaction SHALL complete.
REQ-029 last_grant SHALL update on every grant, but not on an aborted grant.

Reset
REQ-030 rst=1 SHALL asynchronously force state=IDLE, last_grant=INST, i_ready=0, d_ready=0, i_rdata=0, d_rdata=0, all registered mem_* command fields=0, and busy=0.
REQ-031 Reset mid-transaction SHALL drop the transaction with no ready pulse; the first cycle after reset release SHALL be IDLE.

Structure
REQ-032 State encodings (IDLE, INST, DATA, RESP), grant IDs, size codes (2'b00, 2'b01, 2'b10) and remap defaults SHALL reside in a shared package, mem_arb_pkg.
REQ-033 The d_wen-to-mem_size decode plus the address remap SHALL be one combinational sub-module, mem_req_decode.
REQ-034 All other logic SHALL be a single flat FSM with registered outputs.

Verification
REQ-035 Inst only: i_req=1, i_addr=0xbfc00000, mem_ready after 3 cycles with mem_data=0x3c080001 -> mem_access for 3 cycles, mem_a=0xbfc00000, sel=1111, size=10; i_ready 1-cycle pulse; i_rdata=0x3c080001.
REQ-036 Simultaneous requests after reset: i_req=d_req=1 -> DATA granted first, then INST; next simultaneous -> DATA again (alternation verified over 4 rounds).
REQ-037 Store remap: d_write=1, d_addr=0xbfaf8000, d_wen=0011, d_wdata=0x1234 -> mem_a=0x1faf8000, size=01, sel=0011, mem_write=1, d_ready pulse.
REQ-038 Flush abort: d_req granted, flush=1 two cycles into DATA, mem_ready never asserted -> mem_access low next cycle, no d_ready, state IDLE, then pending i_req served.
REQ-039 Held request: requester keeps i_req=1 through RESP -> exactly one i_ready per mem_ready, mem_access low during RESP.
REQ-040 Reset mid-DATA: rst=1 while mem_access=1 -> all outputs 0 immediately, no d_ready after release.
